// File: rtl/bisr_repair_table.sv
`default_nettype none
// ============================================================================
// Module   : bisr_repair_table
// Purpose  : Built-in self-repair table. During a BIST session it records the
//            failing addresses into a small table of spare-row entries. After
//            the session ends, the table is frozen and used to look up
//            functional accesses that must be steered to a spare row.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ENTRIES      number of spare-row entries (2..8)
//   AW           fault/functional address width ({bank, row})
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bist_en      BIST session enable; a rising level starts a new collection
//   fail_in      per-cycle fail strobe from the BIST compare stage
//   fail_addr    failing address, valid while fail_in=1
//   mem_req      functional access request
//   mem_addr     functional access address
//   repair_hit   registered: last cycle's access matched a valid entry
//   repair_idx   registered: lowest matching entry index (0 when no hit)
//   repair_cnt   number of valid entries
//   repair_full  repair_cnt == ENTRIES
//   repair_ovf   sticky: a fault was dropped because the table was full
//   repair_ready table is frozen and lookups are enabled
// Configuration
//   BISR_DEDUP_EN  when defined, a fault whose address is already stored is
//                  dropped (no new entry, no overflow)
// ============================================================================
module bisr_repair_table #(
  parameter int ENTRIES = 4,
  parameter int AW      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bist_en,
  input  logic                       fail_in,
  input  logic [AW-1:0]              fail_addr,
  input  logic                       mem_req,
  input  logic [AW-1:0]              mem_addr,
  output logic                       repair_hit,
  output logic [$clog2(ENTRIES)-1:0] repair_idx,
  output logic [$clog2(ENTRIES):0]   repair_cnt,
  output logic                       repair_full,
  output logic                       repair_ovf,
  output logic                       repair_ready
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   entry [ENTRIES];
  logic [ENTRIES-1:0] valid;
  logic [CW-1:0]   cnt;
  logic            ovf;
  logic            full;
  logic            start;
  logic            dup;
  logic [ENTRIES-1:0] mem_match;
  logic            hit_c;
  logic [IW-1:0]   idx_c;
  logic            hit_q;
  logic [IW-1:0]   idx_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bist_en)  state_nxt = S_COLLECT;
      S_COLLECT: if (!bist_en) state_nxt = S_DONE;
      S_DONE:    if (bist_en)  state_nxt = S_COLLECT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // A new session wipes the previous results on the very edge it starts.
  assign start = (state_nxt == S_COLLECT) && (state != S_COLLECT);
  assign full  = (cnt == CW'(ENTRIES));

  // ------------------------------------------------------- duplicate check
`ifdef BISR_DEDUP_EN
  logic [ENTRIES-1:0] fail_match;
  for (genvar i = 0; i < ENTRIES; i++) begin : g_fail_cmp
    assign fail_match[i] = valid[i] && (entry[i] == fail_addr);
  end
  assign dup = |fail_match;
`else
  assign dup = 1'b0;
`endif

  // ------------------------------------------------------------ table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) entry[i] <= '0;
    end else if (start) begin
      valid <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (state == S_COLLECT && fail_in && !dup) begin
      if (!full) begin
        entry[cnt[IW-1:0]] <= fail_addr;
        valid[cnt[IW-1:0]] <= 1'b1;
        cnt                <= cnt + CW'(1);
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ lookup
  for (genvar i = 0; i < ENTRIES; i++) begin : g_mem_cmp
    assign mem_match[i] = valid[i] && (entry[i] == mem_addr);
  end

  assign hit_c = |mem_match;

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    idx_c = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (mem_match[i]) idx_c = IW'(i);
    end
  end

  // Only register a result when the FSM stays in DONE, so the outputs read
  // zero for every cycle spent in IDLE or COLLECT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= 1'b0;
      idx_q <= '0;
    end else if (state == S_DONE && state_nxt == S_DONE && mem_req) begin
      hit_q <= hit_c;
      idx_q <= idx_c;
    end else begin
      hit_q <= 1'b0;
      idx_q <= '0;
    end
  end

  assign repair_hit   = hit_q;
  assign repair_idx   = idx_q;
  assign repair_cnt   = cnt;
  assign repair_full  = full;
  assign repair_ovf   = ovf;
  assign repair_ready = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bisr_repair_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_bisr_repair_table
// Purpose  : Self-checking bench for bisr_repair_table. Directed scenarios
//            check fixed expected values; a randomized phase compares every
//            cycle against a list-based reference model of the repair table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bisr_repair_table;

  localparam int ENTRIES = 4;
  localparam int AW      = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          bist_en;
  logic          fail_in;
  logic [AW-1:0] fail_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          repair_hit;
  logic [1:0]    repair_idx;
  logic [2:0]    repair_cnt;
  logic          repair_full;
  logic          repair_ovf;
  logic          repair_ready;

  int checks = 0;
  int errors = 0;

  bisr_repair_table #(.ENTRIES(ENTRIES), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bist_en      (bist_en),
    .fail_in      (fail_in),
    .fail_addr    (fail_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .repair_hit   (repair_hit),
    .repair_idx   (repair_idx),
    .repair_cnt   (repair_cnt),
    .repair_full  (repair_full),
    .repair_ovf   (repair_ovf),
    .repair_ready (repair_ready)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------- reference model
  // mode: 0 = idle, 1 = collecting, 2 = frozen table
  int            m_mode;
  logic [AW-1:0] m_tab [$];
  bit            m_ovf;
  bit            m_hit;
  int            m_idx;

  task automatic model_reset();
    m_mode = 0;
    m_tab.delete();
    m_ovf  = 0;
    m_hit  = 0;
    m_idx  = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit found;
    bit dup;
    int first;
    found = 0;
    first = 0;
    for (int i = m_tab.size() - 1; i >= 0; i--)
      if (m_tab[i] == mem_addr) begin found = 1; first = i; end
    m_hit = (m_mode == 2) && !bist_en && mem_req && found;
    m_idx = m_hit ? first : 0;

    if (m_mode == 1 && fail_in) begin
      dup = 0;
`ifdef BISR_DEDUP_EN
      foreach (m_tab[i]) if (m_tab[i] == fail_addr) dup = 1;
`endif
      if (!dup) begin
        if (m_tab.size() < ENTRIES) m_tab.push_back(fail_addr);
        else                        m_ovf = 1;
      end
    end

    if (m_mode == 1) begin
      if (!bist_en) m_mode = 2;
    end else if (bist_en) begin
      m_mode = 1;
      m_tab.delete();
      m_ovf = 0;
    end
  endtask

  // ---------------------------------------------------- stimulus helpers
  task automatic set_in(input logic be, input logic fi, input logic [AW-1:0] fa,
                        input logic mr, input logic [AW-1:0] ma);
    bist_en   = be;
    fail_in   = fi;
    fail_addr = fa;
    mem_req   = mr;
    mem_addr  = ma;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------- scenarios
  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 16'h0, 0, 16'h0);
    model_reset();
    #12;
    checks++;
    if ({repair_hit, repair_idx, repair_cnt, repair_full, repair_ovf, repair_ready} !== 9'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=000000000",
               {repair_hit, repair_idx, repair_cnt, repair_full, repair_ovf, repair_ready});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tick();
    checks++;
    if (repair_ready !== 1'b0 || repair_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle_wait ready=%b cnt=%0d required ready=0 cnt=0", repair_ready, repair_cnt);
    end
  endtask

  task automatic test_capture();
    set_in(1, 0, 16'h0, 0, 16'h0); tick();
    set_in(1, 1, 16'h0412, 0, 16'h0); tick();
    set_in(1, 1, 16'h0000, 0, 16'h0); tick();
    set_in(1, 1, 16'hFC3F, 0, 16'h0); tick();
    checks++;
    if (repair_cnt !== 3'd3 || repair_ready !== 1'b0) begin
      errors++;
      $display("FAIL capture_collect cnt=%0d ready=%b required cnt=3 ready=0", repair_cnt, repair_ready);
    end
    set_in(0, 0, 16'h0, 0, 16'h0); tick();
    checks++;
    if (repair_cnt !== 3'd3 || repair_ready !== 1'b1 || repair_ovf !== 1'b0 || repair_full !== 1'b0) begin
      errors++;
      $display("FAIL capture_done cnt=%0d ready=%b ovf=%b full=%b required cnt=3 ready=1 ovf=0 full=0",
               repair_cnt, repair_ready, repair_ovf, repair_full);
    end
  endtask

  task automatic test_lookup();
    set_in(0, 0, 16'h0, 1, 16'hFC3F); tick();
    checks++;
    if (repair_hit !== 1'b1 || repair_idx !== 2'd2) begin
      errors++;
      $display("FAIL lookup_fc3f hit=%b idx=%0d required hit=1 idx=2", repair_hit, repair_idx);
    end
    set_in(0, 0, 16'h0, 1, 16'h0413); tick();
    checks++;
    if (repair_hit !== 1'b0 || repair_idx !== 2'd0) begin
      errors++;
      $display("FAIL lookup_miss hit=%b idx=%0d required hit=0 idx=0", repair_hit, repair_idx);
    end
    set_in(0, 0, 16'h0, 1, 16'h0000); tick();
    checks++;
    if (repair_hit !== 1'b1 || repair_idx !== 2'd1) begin
      errors++;
      $display("FAIL lookup_zero hit=%b idx=%0d required hit=1 idx=1", repair_hit, repair_idx);
    end
    set_in(0, 0, 16'h0, 0, 16'hFC3F); tick();
    checks++;
    if (repair_hit !== 1'b0 || repair_idx !== 2'd0) begin
      errors++;
      $display("FAIL lookup_noreq hit=%b idx=%0d required hit=0 idx=0", repair_hit, repair_idx);
    end
  endtask

  task automatic test_edge_fail();
    set_in(1, 0, 16'h0, 1, 16'hFC3F); tick();
    checks++;
    if (repair_cnt !== 3'd0 || repair_ready !== 1'b0 || repair_hit !== 1'b0) begin
      errors++;
      $display("FAIL rerun_clear cnt=%0d ready=%b hit=%b required 0 0 0", repair_cnt, repair_ready, repair_hit);
    end
    set_in(1, 1, 16'h1111, 0, 16'h0); tick();
    set_in(0, 1, 16'h2222, 0, 16'h0); tick();
    checks++;
    if (repair_cnt !== 3'd2 || repair_ready !== 1'b1) begin
      errors++;
      $display("FAIL edge_capture cnt=%0d ready=%b required cnt=2 ready=1", repair_cnt, repair_ready);
    end
    set_in(0, 1, 16'h3333, 0, 16'h0); tick();
    checks++;
    if (repair_cnt !== 3'd2) begin
      errors++;
      $display("FAIL done_ignores_fail cnt=%0d required 2", repair_cnt);
    end
    set_in(0, 0, 16'h0, 1, 16'h2222); tick();
    checks++;
    if (repair_hit !== 1'b1 || repair_idx !== 2'd1) begin
      errors++;
      $display("FAIL edge_lookup hit=%b idx=%0d required hit=1 idx=1", repair_hit, repair_idx);
    end
    set_in(0, 0, 16'h0, 1, 16'h3333); tick();
    checks++;
    if (repair_hit !== 1'b0) begin
      errors++;
      $display("FAIL done_fail_not_stored hit=%b required 0", repair_hit);
    end
  endtask

  task automatic fill_overflow();
    logic [AW-1:0] addrs [5];
    addrs = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
    set_in(1, 0, 16'h0, 0, 16'h0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, addrs[i], 0, 16'h0); tick();
      if (i == 3) begin
        checks++;
        if (repair_full !== 1'b1 || repair_ovf !== 1'b0) begin
          errors++;
          $display("FAIL full_no_ovf full=%b ovf=%b required full=1 ovf=0", repair_full, repair_ovf);
        end
      end
    end
    set_in(0, 0, 16'h0, 0, 16'h0); tick();
  endtask

  task automatic test_overflow();
    fill_overflow();
    checks++;
    if (repair_cnt !== 3'd4 || repair_full !== 1'b1 || repair_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow cnt=%0d full=%b ovf=%b required cnt=4 full=1 ovf=1",
               repair_cnt, repair_full, repair_ovf);
    end
    set_in(0, 0, 16'h0, 1, 16'h0404); tick();
    checks++;
    if (repair_hit !== 1'b1 || repair_idx !== 2'd3) begin
      errors++;
      $display("FAIL overflow_entry3 hit=%b idx=%0d required hit=1 idx=3", repair_hit, repair_idx);
    end
    set_in(0, 0, 16'h0, 1, 16'h0505); tick();
    checks++;
    if (repair_hit !== 1'b0) begin
      errors++;
      $display("FAIL overflow_dropped hit=%b required 0", repair_hit);
    end
  endtask

  task automatic test_dedup();
    logic [2:0] exp_cnt;
`ifdef BISR_DEDUP_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    set_in(1, 0, 16'h0, 0, 16'h0); tick();
    checks++;
    if (repair_cnt !== 3'd0 || repair_ovf !== 1'b0 || repair_full !== 1'b0) begin
      errors++;
      $display("FAIL session_clear cnt=%0d ovf=%b full=%b required 0 0 0", repair_cnt, repair_ovf, repair_full);
    end
    set_in(1, 1, 16'h0412, 0, 16'h0); tick();
    set_in(1, 1, 16'h0412, 0, 16'h0); tick();
    set_in(0, 0, 16'h0, 0, 16'h0); tick();
    checks++;
    if (repair_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL dedup_cnt cnt=%0d required %0d", repair_cnt, exp_cnt);
    end
    set_in(0, 0, 16'h0, 1, 16'h0412); tick();
    checks++;
    if (repair_hit !== 1'b1 || repair_idx !== 2'd0) begin
      errors++;
      $display("FAIL dedup_lookup hit=%b idx=%0d required hit=1 idx=0", repair_hit, repair_idx);
    end
  endtask

  task automatic test_reset_rerun();
    set_in(1, 0, 16'h0, 0, 16'h0); tick();
    set_in(1, 1, 16'h0A0A, 0, 16'h0); tick();
    set_in(1, 1, 16'h0B0B, 0, 16'h0); tick();
    set_in(0, 0, 16'h0, 0, 16'h0);
    #3 rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if ({repair_hit, repair_idx, repair_cnt, repair_full, repair_ovf, repair_ready} !== 9'h0) begin
      errors++;
      $display("FAIL async_reset got=%b required=000000000",
               {repair_hit, repair_idx, repair_cnt, repair_full, repair_ovf, repair_ready});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tick();
    checks++;
    if (repair_ready !== 1'b0 || repair_cnt !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_idle ready=%b cnt=%0d required ready=0 cnt=0", repair_ready, repair_cnt);
    end
    fill_overflow();
    set_in(1, 0, 16'h0, 0, 16'h0); tick();
    checks++;
    if (repair_cnt !== 3'd0 || repair_ovf !== 1'b0 || repair_full !== 1'b0 || repair_ready !== 1'b0) begin
      errors++;
      $display("FAIL rerun_from_done cnt=%0d ovf=%b full=%b ready=%b required all 0",
               repair_cnt, repair_ovf, repair_full, repair_ready);
    end
    set_in(0, 0, 16'h0, 0, 16'h0); tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [6];
    logic [8:0] got;
    logic [8:0] exp;
    logic       be;
    pool = '{16'h0000, 16'h0412, 16'hFC3F, 16'h8001, 16'h1234, 16'hFFFF};
    be = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) be = ~be;
      set_in(be, ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 4) == 0) ? AW'($urandom) : pool[$urandom_range(0, 5)],
             ($urandom_range(0, 1) == 1), pool[$urandom_range(0, 5)]);
      tick();
      exp = {m_hit, 2'(m_idx), 3'(m_tab.size()), (m_tab.size() == ENTRIES), m_ovf, (m_mode == 2)};
      got = {repair_hit, repair_idx, repair_cnt, repair_full, repair_ovf, repair_ready};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cycle=%0d {hit,idx,cnt,full,ovf,ready} got=%b required=%b", n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_lookup();
    test_edge_fail();
    test_overflow();
    test_dedup();
    test_reset_rerun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
